adv_channel_scheduler: RTL

Hop scheduler for the BLE sniffer's advertising-channel front end. It cycles the RF tuner through the enabled advertising channels (37, 38, 39). On each channel it holds the sync detector in reset while the tuner settles, then releases it for a fixed listen window. If the detector reports sync, the scheduler stays on the channel until the packet ends or a capture timeout fires, then hops.

---
 rtl/adv_channel_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/adv_channel_scheduler.sv
// Advertising-channel hop scheduler: tunes each enabled channel (37/38/39), settles
// the sync detector, listens for a dwell window, and holds the channel while a packet is captured.
module adv_channel_scheduler #(
    parameter int unsigned SETTLE_CYCLES   = 64,
    parameter int unsigned DWELL_CYCLES    = 100000,
    parameter int unsigned CAPTURE_TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [2:0]  channel_mask,
    input  logic        sync_found,
    input  logic        sync_valid,
    output logic [5:0]  rf_channel,
    output logic        rf_tune,
    output logic        det_rst_n,
    output logic        capturing,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] hop_count,
    output logic [15:0] pkt_count
);

    localparam int unsigned CNT_W = 24;
    localparam int unsigned CNT_SETTLE  = SETTLE_CYCLES - 1;
    localparam int unsigned CNT_DWELL   = DWELL_CYCLES - 1;
    localparam int unsigned CNT_CAPTURE = CAPTURE_TIMEOUT - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TUNE,
        S_SETTLE,
        S_DWELL,
        S_CAPTURE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic               hop_c;
    logic               timeout_c;

    logic [5:0]         rf_channel_q, rf_channel_d;
    logic               rf_tune_q, rf_tune_d;
    logic               det_rst_n_q, det_rst_n_d;
    logic               capturing_q, capturing_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;
    logic [15:0]        hop_count_q, hop_count_d;
    logic [15:0]        pkt_count_q, pkt_count_d;

    // First enabled index strictly after cur, wrapping 0->1->2->0; cur itself if it is the only one.
    function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [2:0] mask);
        logic [1:0] j;
        logic [1:0] r;
        logic       found;
        j     = cur;
        r     = cur;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            j = (j == 2'd2) ? 2'd0 : j + 2'd1;
            if (mask[j] && !found) begin
                r     = j;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        hop_c     = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && (channel_mask != 3'b000)) begin
                    idx_d   = next_idx(2'd2, channel_mask);
                    state_d = S_TUNE;
                end
            end
            S_TUNE: begin
                state_d = S_SETTLE;
                cnt_d   = CNT_W'(CNT_SETTLE);
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_DWELL;
                    cnt_d   = CNT_W'(CNT_DWELL);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DWELL: begin
                // A sync in the last window cycle still wins over the hop.
                if (sync_found) begin
                    state_d = S_CAPTURE;
                    cnt_d   = CNT_W'(CNT_CAPTURE);
                end else if (cnt_q == '0) begin
                    hop_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                if (!sync_found) begin
                    hop_c = 1'b1;
                end else if (sync_valid) begin
                    cnt_d = CNT_W'(CNT_CAPTURE);
                end else if (cnt_q == '0) begin
                    timeout_c = 1'b1;
                    hop_c     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hop_c) begin
            if (channel_mask == 3'b000) begin
                state_d = S_IDLE;
            end else begin
                idx_d   = next_idx(idx_q, channel_mask);
                state_d = S_TUNE;
            end
        end

        // Dropping enable aborts silently from any state.
        if (!enable) begin
            state_d   = S_IDLE;
            idx_d     = idx_q;
            timeout_c = 1'b0;
        end
    end

    // Registered outputs are computed from the state being entered.
    always_comb begin
        rf_tune_d     = (state_d == S_TUNE);
        rf_channel_d  = (state_d == S_TUNE) ? 6'(6'd37 + 6'(idx_d)) : rf_channel_q;
        det_rst_n_d   = (state_d == S_DWELL) || (state_d == S_CAPTURE);
        capturing_d   = (state_d == S_CAPTURE);
        busy_d        = (state_d != S_IDLE);
        timeout_err_d = timeout_c;
        hop_count_d   = hop_count_q + 16'((state_d == S_TUNE) ? 1 : 0);
        pkt_count_d   = pkt_count_q +
                        16'(((state_d == S_CAPTURE) && (state_q == S_DWELL)) ? 1 : 0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            rf_channel_q  <= 6'd37;
            rf_tune_q     <= 1'b0;
            det_rst_n_q   <= 1'b0;
            capturing_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            hop_count_q   <= 16'd0;
            pkt_count_q   <= 16'd0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            rf_channel_q  <= rf_channel_d;
            rf_tune_q     <= rf_tune_d;
            det_rst_n_q   <= det_rst_n_d;
            capturing_q   <= capturing_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            hop_count_q   <= hop_count_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    assign rf_channel  = rf_channel_q;
    assign rf_tune     = rf_tune_q;
    assign det_rst_n   = det_rst_n_q;
    assign capturing   = capturing_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign hop_count   = hop_count_q;
    assign pkt_count   = pkt_count_q;

endmodule
